// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, widths and saturating add for the BIST sequencer
package bist_pkg;

   localparam int BIST_ERR_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      RUN,
      RELEASE,
      FINISH
   } sched_state_t;

   function automatic logic [BIST_ERR_W-1:0] sat_add(input logic [BIST_ERR_W-1:0] a,
                                                    input logic [BIST_ERR_W-1:0] b);
      logic [BIST_ERR_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[BIST_ERR_W] ? '1 : sum[BIST_ERR_W-1:0];
   endfunction

endpackage

// File: rtl/bist_scheduler_if.sv
// rtl/bist_scheduler_if.sv - test-access and per-controller signals of the BIST sequencer
interface bist_scheduler_if #(
   parameter int NUM_MEMS = 4
);
   import bist_pkg::*;

   localparam int CUR_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;

   logic                           sched_start;
   logic                           sched_abort;
   logic [NUM_MEMS-1:0]            mem_mask;
   logic [NUM_MEMS-1:0]            bist_start;
   logic [NUM_MEMS-1:0]            bist_done;
   logic [NUM_MEMS-1:0]            bist_pass;
   logic [BIST_ERR_W*NUM_MEMS-1:0] error_count;
   logic                           sched_busy;
   logic                           sched_done;
   logic                           sched_pass;
   logic [NUM_MEMS-1:0]            fail_map;
   logic [NUM_MEMS-1:0]            timeout_map;
   logic [BIST_ERR_W-1:0]          total_errors;
   logic [CUR_W-1:0]               cur_mem;

   // master: test access logic plus the controllers; slave: the scheduler
   modport master (
      output sched_start, sched_abort, mem_mask, bist_done, bist_pass, error_count,
      input  bist_start, sched_busy, sched_done, sched_pass, fail_map, timeout_map,
             total_errors, cur_mem
   );

   modport slave (
      input  sched_start, sched_abort, mem_mask, bist_done, bist_pass, error_count,
      output bist_start, sched_busy, sched_done, sched_pass, fail_map, timeout_map,
             total_errors, cur_mem
   );

endinterface

// File: rtl/bist_sched_timer.sv
// rtl/bist_sched_timer.sv - per-memory watchdog counter, expires at TIMEOUT_CYCLES-1
module bist_sched_timer #(
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/bist_scheduler.sv
// rtl/bist_scheduler.sv - runs the memory BIST controllers in index order and gathers a chip result
module bist_scheduler
   import bist_pkg::*;
#(
   parameter int NUM_MEMS       = 4,
   parameter int TIMEOUT_CYCLES = 8192
) (
   input  logic            clk,
   input  logic            rst_n,
   bist_scheduler_if.slave bus
);

   localparam int CUR_W = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
   localparam logic [CUR_W-1:0] LAST_MEM = CUR_W'(NUM_MEMS - 1);

   sched_state_t          state;
   logic [NUM_MEMS-1:0]   mask_q;
   logic                  armed;
   logic                  expired;
   logic                  done_sel;
   logic                  pass_sel;
   logic [BIST_ERR_W-1:0] err_sel;
   logic                  in_seq;

   assign done_sel = bus.bist_done[bus.cur_mem];
   assign pass_sel = bus.bist_pass[bus.cur_mem];
   assign err_sel  = bus.error_count[bus.cur_mem*BIST_ERR_W +: BIST_ERR_W];
   assign in_seq   = (state == SELECT) || (state == RUN) || (state == RELEASE);

   bist_sched_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state == SELECT),
      .enable (state == RUN),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         mask_q           <= '0;
         armed            <= 1'b0;
         bus.bist_start   <= '0;
         bus.sched_busy   <= 1'b0;
         bus.sched_done   <= 1'b0;
         bus.sched_pass   <= 1'b0;
         bus.fail_map     <= '0;
         bus.timeout_map  <= '0;
         bus.total_errors <= '0;
         bus.cur_mem      <= '0;
      end else if (in_seq && bus.sched_abort) begin
         // the interrupted memory is left unmarked; results so far are kept
         state          <= FINISH;
         bus.bist_start <= '0;
         bus.sched_busy <= 1'b0;
         bus.sched_done <= 1'b1;
         bus.sched_pass <= 1'b0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if (bus.sched_start) begin
                  state            <= SELECT;
                  mask_q           <= bus.mem_mask;
                  bus.fail_map     <= '0;
                  bus.timeout_map  <= '0;
                  bus.total_errors <= '0;
                  bus.sched_done   <= 1'b0;
                  bus.sched_pass   <= 1'b0;
                  bus.sched_busy   <= 1'b1;
                  bus.cur_mem      <= '0;
               end
            end
            SELECT: begin
               if (mask_q[bus.cur_mem]) begin
                  state          <= RUN;
                  armed          <= 1'b0;
                  bus.bist_start <= NUM_MEMS'(1) << bus.cur_mem;
               end else if (bus.cur_mem == LAST_MEM) begin
                  state          <= FINISH;
                  bus.sched_busy <= 1'b0;
                  bus.sched_done <= 1'b1;
                  bus.sched_pass <= (bus.fail_map == '0);
               end else begin
                  bus.cur_mem <= bus.cur_mem + 1'b1;
               end
            end
            RUN: begin
               // a done still high from the previous run is ignored until it has been seen low
               if (!done_sel) begin
                  armed <= 1'b1;
               end
               if (armed && done_sel) begin
                  state                         <= RELEASE;
                  bus.bist_start                <= '0;
                  bus.fail_map[bus.cur_mem]     <= ~pass_sel;
                  bus.total_errors              <= sat_add(bus.total_errors, err_sel);
               end else if (expired) begin
                  state                         <= RELEASE;
                  bus.bist_start                <= '0;
                  bus.fail_map[bus.cur_mem]     <= 1'b1;
                  bus.timeout_map[bus.cur_mem]  <= 1'b1;
               end
            end
            RELEASE: begin
               if (bus.cur_mem == LAST_MEM) begin
                  state          <= FINISH;
                  bus.sched_busy <= 1'b0;
                  bus.sched_done <= 1'b1;
                  bus.sched_pass <= (bus.fail_map == '0);
               end else begin
                  state       <= SELECT;
                  bus.cur_mem <= bus.cur_mem + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_scheduler.sv
// tb/tb_bist_scheduler.sv - randomized self-checking bench for bist_scheduler
module tb_bist_scheduler;
   import bist_pkg::*;

   localparam int NM = 4;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bist_scheduler_if #(.NUM_MEMS(NM)) bus ();

   bist_scheduler #(
      .NUM_MEMS      (NM),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   // controller behaviour for the current run of each memory
   int          lat  [NM];
   int          drop [NM];
   bit          hang [NM];
   bit          pv   [NM];
   logic [31:0] ev   [NM];
   int          cnt  [NM];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // controller models: done is sticky, drops `drop` cycles into a run, rises at cycle `lat`
   initial begin
      bus.bist_done   = '0;
      bus.bist_pass   = '0;
      bus.error_count = '0;
      for (int i = 0; i < NM; i++) cnt[i] = 0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < NM; i++) begin
            if (bus.bist_start[i]) begin
               if (cnt[i] == drop[i]) bus.bist_done[i] = 1'b0;
               if (!hang[i] && cnt[i] == lat[i]) begin
                  bus.bist_done[i]           = 1'b1;
                  bus.bist_pass[i]           = pv[i];
                  bus.error_count[32*i +: 32] = ev[i];
               end
               cnt[i]++;
            end else begin
               cnt[i] = 0;
            end
         end
      end
   end

   task automatic set_plain(input logic [31:0] err);
      for (int i = 0; i < NM; i++) begin
         pv[i] = 1'b1; hang[i] = 1'b0; drop[i] = 1; lat[i] = 5; ev[i] = err;
      end
   endtask

   task automatic set_random();
      for (int i = 0; i < NM; i++) begin
         pv[i]   = ($urandom_range(0, 3) != 0);
         hang[i] = ($urandom_range(0, 7) == 0);
         drop[i] = $urandom_range(0, 3);
         lat[i]  = drop[i] + $urandom_range(1, 20);
         ev[i]   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 100));
      end
   endtask

   task automatic run_seq(input logic [3:0] mask, input string name);
      logic [3:0]  efail, eto, prev;
      logic [63:0] acc;
      logic [31:0] etot;
      logic [15:0] ord_obs, ord_exp;
      int          ecyc, k, viol, n_obs, n_exp;
      int          hi   [NM];
      int          erun [NM];

      efail = '0; eto = '0; acc = '0; ecyc = 0; n_exp = 0; ord_exp = '0;
      for (int i = 0; i < NM; i++) begin
         hi[i] = 0;
         if (mask[i]) begin
            erun[i] = hang[i] ? TO : lat[i] + 1;
            ecyc += 2 + erun[i];
            ord_exp[4*n_exp +: 4] = 4'(i);
            n_exp++;
            if (hang[i]) begin
               eto[i] = 1'b1; efail[i] = 1'b1;
            end else begin
               if (!pv[i]) efail[i] = 1'b1;
               acc += 64'(ev[i]);
            end
         end else begin
            erun[i] = 0;
            ecyc += 1;
         end
      end
      etot = (acc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : acc[31:0];

      @(negedge clk);
      bus.mem_mask    = mask;
      bus.sched_start = 1'b1;
      @(negedge clk);
      bus.sched_start = 1'b0;
      check({name, " entry"}, {bus.sched_busy, bus.sched_done, bus.sched_pass, bus.bist_start},
            {3'b100, 4'b0000});

      k = 0; viol = 0; n_obs = 0; prev = '0; ord_obs = '0;
      while (1) begin
         // a start request mid-sequence, with a different mask, must be ignored
         if (k == 3) begin bus.sched_start = 1'b1; bus.mem_mask = ~mask; end
         if (k == 4) bus.sched_start = 1'b0;
         if ($countones(bus.bist_start) > 1) viol++;
         for (int i = 0; i < NM; i++) if (bus.bist_start[i]) hi[i]++;
         if (bus.bist_start != 0 && bus.bist_start != prev) begin
            for (int i = 0; i < NM; i++)
               if (bus.bist_start[i] && n_obs < 4) ord_obs[4*n_obs +: 4] = 4'(i);
            n_obs++;
         end
         prev = bus.bist_start;
         if (bus.sched_done || k >= 2000) break;
         @(negedge clk);
         k++;
      end
      bus.sched_start = 1'b0;

      check({name, " cycles"}, 64'(k), 64'(ecyc));
      check({name, " order"}, {32'(n_obs), 16'h0, ord_obs}, {32'(n_exp), 16'h0, ord_exp});
      check({name, " onehot"}, 64'(viol), 64'd0);
      for (int i = 0; i < NM; i++)
         check($sformatf("%s start_len%0d", name, i), 64'(hi[i]), 64'(erun[i]));
      check({name, " fail_map"}, 64'(bus.fail_map), 64'(efail));
      check({name, " timeout_map"}, 64'(bus.timeout_map), 64'(eto));
      check({name, " total_errors"}, 64'(bus.total_errors), 64'(etot));
      check({name, " done_pass_busy"}, {bus.sched_done, bus.sched_pass, bus.sched_busy},
            {1'b1, (efail == 4'b0000), 1'b0});
   endtask

   initial begin
      int k;
      bus.sched_start = 1'b0;
      bus.sched_abort = 1'b0;
      bus.mem_mask    = '0;
      set_plain(32'd0);

      repeat (3) @(negedge clk);
      check("reset outputs", {bus.bist_start, bus.sched_busy, bus.sched_done, bus.sched_pass,
            bus.fail_map, bus.timeout_map, bus.total_errors, bus.cur_mem}, 64'd0);
      rst_n = 1'b1;

      set_plain(32'd0);
      run_seq(4'b1111, "all_pass");

      set_plain(32'd0);
      pv[2] = 1'b0; ev[2] = 32'd5; ev[3] = 32'd7;
      run_seq(4'b1111, "mem2_fail");

      set_plain(32'd3);
      run_seq(4'b1010, "mask_1010");

      set_plain(32'd1);
      hang[1] = 1'b1;
      run_seq(4'b1111, "mem1_timeout");

      set_plain(32'd2);
      drop[0] = 3; lat[0] = 8; ev[0] = 32'd99;
      run_seq(4'b0001, "stale_done");

      set_plain(32'd0);
      run_seq(4'b0000, "empty_mask");

      set_plain(32'd0);
      ev[0] = 32'hFFFF_FFF0; ev[1] = 32'h20;
      run_seq(4'b0011, "saturate");

      for (int r = 0; r < 20; r++) begin
         set_random();
         run_seq(4'($urandom_range(0, 15)), $sformatf("rand%0d", r));
      end

      // abort during memory 1
      set_plain(32'd1);
      drop[1] = 0; lat[1] = 40;
      @(negedge clk);
      bus.mem_mask = 4'b1111; bus.sched_start = 1'b1;
      @(negedge clk);
      bus.sched_start = 1'b0;
      k = 0;
      while (!bus.bist_start[1] && k < 200) begin @(negedge clk); k++; end
      check("abort reach mem1", 64'(bus.bist_start[1]), 64'd1);
      repeat (5) @(negedge clk);
      bus.sched_abort = 1'b1;
      @(negedge clk);
      bus.sched_abort = 1'b0;
      check("abort state", {bus.bist_start, bus.sched_busy, bus.sched_done, bus.sched_pass},
            {4'b0000, 3'b010});
      check("abort maps", {bus.fail_map, bus.timeout_map, bus.total_errors}, {8'h00, 32'd1});
      bus.sched_abort = 1'b1;
      repeat (3) @(negedge clk);
      bus.sched_abort = 1'b0;
      check("abort sticky", {bus.sched_busy, bus.sched_done, bus.sched_pass, bus.bist_start},
            {3'b010, 4'b0000});

      // asynchronous reset during memory 1
      set_plain(32'd4);
      lat[1] = 30;
      @(negedge clk);
      bus.mem_mask = 4'b1111; bus.sched_start = 1'b1;
      @(negedge clk);
      bus.sched_start = 1'b0;
      k = 0;
      while (!bus.bist_start[1] && k < 200) begin @(negedge clk); k++; end
      check("reset reach mem1", 64'(bus.bist_start[1]), 64'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset", {bus.bist_start, bus.sched_busy, bus.sched_done, bus.sched_pass,
            bus.fail_map, bus.timeout_map, bus.total_errors, bus.cur_mem}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      set_random();
      run_seq(4'b1111, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
